// File: rtl/fifo_ctrl_if.sv
// FIFO controller bus: request inputs, storage access strobes/addresses,
// occupancy status and sticky error flags. clk/rst are kept outside.
interface fifo_ctrl_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  wr_req;
   logic                  rd_req;
   logic                  err_clr;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  ren;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  rvalid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   // Requester side: issues push/pop/clear, observes strobes and status.
   modport master (
      output wr_req, rd_req, err_clr,
      input  wen, waddr, ren, raddr, rvalid, full, empty,
             almost_full, almost_empty, count, overflow, underflow
   );

   // Controller side.
   modport slave (
      input  wr_req, rd_req, err_clr,
      output wen, waddr, ren, raddr, rvalid, full, empty,
             almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a dual-port FIFO storage array with a
// 1-cycle registered read. Pointers carry one extra wrap bit so that
// full and empty are distinguishable when the address bits match.
// Optional build macro FIFO_CTRL_ERR_EN adds sticky overflow/underflow
// flags cleared by err_clr; without it both flags are tied low.
module fifo_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2
) (
   input logic         clk,
   input logic         rst,
   fifo_ctrl_if.slave  bus
);
   localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [ADDR_WIDTH:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH:0] rptr_q, rptr_d;
   logic                rvalid_q;
   logic [ADDR_WIDTH:0] count_w;
   logic                full_w;
   logic                empty_w;
   logic                wen_w;
   logic                ren_w;

   // Status is derived only from registered pointers, so it cannot glitch
   // when the requests change within a cycle.
   always_comb begin
      count_w = wptr_q - rptr_q;
      full_w  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
      empty_w = (wptr_q == rptr_q);
      wen_w   = bus.wr_req & ~full_w & ~rst;
      ren_w   = bus.rd_req & ~empty_w & ~rst;
      wptr_d  = wptr_q + (ADDR_WIDTH+1)'(wen_w);
      rptr_d  = rptr_q + (ADDR_WIDTH+1)'(ren_w);
   end

   // Pointer and read-valid registers; rvalid tracks the storage read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         rvalid_q <= ren_w;
      end
   end

   assign bus.wen          = wen_w;
   assign bus.ren          = ren_w;
   assign bus.waddr        = wptr_q[ADDR_WIDTH-1:0];
   assign bus.raddr        = rptr_q[ADDR_WIDTH-1:0];
   assign bus.rvalid       = rvalid_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.count        = count_w;
   assign bus.almost_full  = (count_w >= AF_LVL);
   assign bus.almost_empty = (count_w <= AE_LVL);

`ifdef FIFO_CTRL_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error next-state: a set condition wins over a same-cycle clear.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr_req & full_w)  overflow_d  = 1'b1;
      if (bus.rd_req & empty_w) underflow_d = 1'b1;
   end

   // Sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios followed by random
// push/pop/reset traffic, all compared against an occupancy model built
// from running push/pop totals.
module tb_fifo_ctrl;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: total accepted pushes/pops since reset.
   int   wr_total  = 0;
   int   rd_total  = 0;
   logic rvalid_m  = 1'b0;
   logic ovf_m     = 1'b0;
   logic unf_m     = 1'b0;

   fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive requests, check mid-cycle, advance model at edge.
   task automatic step(input logic w, input logic r, input logic rs, input logic c);
      int   cnt;
      logic full_e, empty_e, wen_e, ren_e;
      bus.wr_req  = w;
      bus.rd_req  = r;
      bus.err_clr = c;
      rst         = rs;
      #2;
      cnt     = wr_total - rd_total;
      full_e  = (cnt == DEPTH);
      empty_e = (cnt == 0);
      wen_e   = w && !full_e && !rs;
      ren_e   = r && !empty_e && !rs;
      chk("wen",          bus.wen,          wen_e);
      chk("ren",          bus.ren,          ren_e);
      chk("waddr",        bus.waddr,        wr_total % DEPTH);
      chk("raddr",        bus.raddr,        rd_total % DEPTH);
      chk("count",        bus.count,        cnt);
      chk("full",         bus.full,         full_e);
      chk("empty",        bus.empty,        empty_e);
      chk("almost_full",  bus.almost_full,  cnt >= AF);
      chk("almost_empty", bus.almost_empty, cnt <= AE);
      chk("rvalid",       bus.rvalid,       rvalid_m);
      chk("overflow",     bus.overflow,     ovf_m);
      chk("underflow",    bus.underflow,    unf_m);
      $display("cyc w=%0b r=%0b rst=%0b clr=%0b count=%0d wen=%0b ren=%0b rvalid=%0b",
               w, r, rs, c, cnt, bus.wen, bus.ren, bus.rvalid);
      @(posedge clk);
      #1;
      if (rs) begin
         wr_total = 0;
         rd_total = 0;
         rvalid_m = 1'b0;
         ovf_m    = 1'b0;
         unf_m    = 1'b0;
      end else begin
         if (wen_e) wr_total++;
         if (ren_e) rd_total++;
         rvalid_m = ren_e;
`ifdef FIFO_CTRL_ERR_EN
         if (c) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
         end
         if (w && full_e)  ovf_m = 1'b1;
         if (r && empty_e) unf_m = 1'b1;
`endif
      end
   endtask

   initial begin
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.err_clr = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      // Reset and idle with rd_req held high.
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      // Fill plus one overflowing push.
      for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      // Drain plus one underflowing pop, then clear errors.
      for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      // Hold count at 5 with simultaneous push+pop across the wrap.
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
      // Boundary pairs at full and at empty.
      for (int i = 0; i < DEPTH - 5; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      // Reset right after a pop at count 7, then push lands at address 0.
      step(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      // Random traffic with phases biased toward filling or draining.
      for (int i = 0; i < 400; i++) begin
         int   pw;
         logic w, r, rs, c;
         pw = ((i / 40) % 2 == 0) ? 75 : 25;
         w  = ($urandom_range(99) < pw);
         r  = ($urandom_range(99) < (100 - pw));
         rs = ($urandom_range(199) == 0);
         c  = ($urandom_range(9) == 0);
         step(w, r, rs, c);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
